// File: rtl/xswitch_pkg.sv
// Shared switch-payload definitions used by both initiator and target units.
// Request payload (TP), MSB first: {tid, iid, wr, adr, vc, stb, dat, sb}
// Response payload (RP), MSB first: {iid, tid, vc, dat}
// Provides default parameter values, the VC-index width rule, payload widths
// and field LSB offsets so both sides of the switch slice fields identically.
package xswitch_pkg;

  localparam int XS_N   = 2;
  localparam int XS_M   = 3;
  localparam int XS_A   = 19;
  localparam int XS_D   = 32;
  localparam int XS_VCN = 2;
  localparam int XS_BUF = 4;
  localparam int XS_SBW = 4;

  // A single VC still needs a one-bit index field in the payload.
  function automatic int vcw_of(input int vcn);
    if (vcn > 1) return $clog2(vcn);
    else return 1;
  endfunction

  function automatic int tp_width(input int m, input int n, input int a,
                                  input int vcw, input int d, input int sbw);
    return m + n + 1 + a + vcw + d / 8 + d + sbw;
  endfunction

  function automatic int rp_width(input int n, input int m, input int vcw, input int d);
    return n + m + vcw + d;
  endfunction

  // Request payload field offsets (target ID occupies the MSBs).
  function automatic int tp_tid_lsb(input int n, input int a, input int vcw,
                                    input int d, input int sbw);
    return n + 1 + a + vcw + d / 8 + d + sbw;
  endfunction

  function automatic int tp_iid_lsb(input int a, input int vcw, input int d, input int sbw);
    return 1 + a + vcw + d / 8 + d + sbw;
  endfunction

  // Response payload field offsets (initiator ID occupies the MSBs).
  function automatic int rp_iid_lsb(input int m, input int vcw, input int d);
    return m + vcw + d;
  endfunction

  function automatic int rp_tid_lsb(input int vcw, input int d);
    return vcw + d;
  endfunction

  function automatic int rp_vc_lsb(input int d);
    return d;
  endfunction

endpackage

// File: rtl/XRs.sv
// Two-entry register slice (skid buffer).
// Full throughput, one cycle of latency; the upstream ready is registered so
// no combinational path runs from rdyo back to rdyi.
// Ports: clk/rstn; vldi/rdyi/dati upstream side; vldo/rdyo/dato downstream side.
// dato is held stable while vldo & !rdyo.
module XRs #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               vldi,
  output logic               rdyi,
  input  logic [D_WIDTH-1:0] dati,
  output logic               vldo,
  input  logic               rdyo,
  output logic [D_WIDTH-1:0] dato
);

  logic               skid_vld;
  logic [D_WIDTH-1:0] skid_dat;

  // A second word can only be absorbed while the skid register is empty.
  assign rdyi = ~skid_vld;

  // Output register refills from the skid entry first, else from the input;
  // when the output is stalled a new word parks in the skid register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vldo     <= 1'b0;
      dato     <= {D_WIDTH{1'b0}};
      skid_vld <= 1'b0;
      skid_dat <= {D_WIDTH{1'b0}};
    end else begin
      if (!vldo || rdyo) begin
        if (skid_vld) begin
          vldo <= 1'b1;
          dato <= skid_dat;
        end else begin
          vldo <= vldi;
          dato <= vldi ? dati : dato;
        end
        skid_vld <= 1'b0;
      end else begin
        if (vldi && !skid_vld) begin
          skid_vld <= 1'b1;
          skid_dat <= dati;
        end else begin
          skid_vld <= skid_vld;
        end
      end
    end
  end

endmodule

// File: rtl/x_init_unit.sv
// Initiator-side network interface between one local master and one switch
// port pair.
//  Request path : m_* -> packed payload -> request slice -> t_vld/t_gnt/t_pld
//  Response path: r_vld/r_gnt/r_pld -> filter -> response slice -> s_*
// A per-VC outstanding counter limits each VC to BUF transactions; it rises on
// request accept and falls when the master takes the response.
// busy flags any non-zero counter; err_mis/err_unf are one-cycle pulses for
// responses dropped because of a wrong initiator ID or an empty counter.
module x_init_unit
  import xswitch_pkg::*;
#(
  parameter  int N   = XS_N,
  parameter  int M   = XS_M,
  parameter  int A   = XS_A,
  parameter  int D   = XS_D,
  parameter  int VCN = XS_VCN,
  parameter  int BUF = XS_BUF,
  parameter  int ID  = 0,
  parameter  int SBW = XS_SBW,
  localparam int VCW = vcw_of(VCN),
  localparam int TP  = tp_width(M, N, A, VCW, D, SBW),
  localparam int RP  = rp_width(N, M, VCW, D)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           m_vld,
  output logic           m_gnt,
  input  logic [M-1:0]   m_tid,
  input  logic           m_wr,
  input  logic [A-1:0]   m_adr,
  input  logic [VCW-1:0] m_vc,
  input  logic [D/8-1:0] m_stb,
  input  logic [D-1:0]   m_dat,
  input  logic [SBW-1:0] m_sb,
  output logic           t_vld,
  input  logic           t_gnt,
  output logic [TP-1:0]  t_pld,
  input  logic           r_vld,
  output logic           r_gnt,
  input  logic [RP-1:0]  r_pld,
  output logic           s_vld,
  input  logic           s_gnt,
  output logic [M-1:0]   s_tid,
  output logic [VCW-1:0] s_vc,
  output logic [D-1:0]   s_dat,
  output logic           busy,
  output logic           err_mis,
  output logic           err_unf
);

  localparam int CW = $clog2(BUF + 1);
  localparam int SW = M + VCW + D;
  localparam int RI = rp_iid_lsb(M, VCW, D);
  localparam int RT = rp_tid_lsb(VCW, D);
  localparam int RV = rp_vc_lsb(D);
  localparam logic [N-1:0]  MY_ID   = N'(ID);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUF);
  localparam logic [VCW:0]  VC_LIM  = (VCW + 1)'(VCN);

  logic [CW-1:0]  cnt [VCN];
  logic [CW-1:0]  m_cnt;
  logic [CW-1:0]  r_cnt;
  logic [VCN-1:0] inc;
  logic [VCN-1:0] dec;

  logic           req_rdy;
  logic           rsp_rdy;
  logic [TP-1:0]  req_pld;
  logic [SW-1:0]  rsp_in;
  logic [SW-1:0]  rsp_out;
  logic           m_vc_ok;
  logic           m_acc;
  logic           s_acc;
  logic           r_acc;
  logic           r_mis;
  logic           r_enq;
  logic [N-1:0]   r_iid;
  logic [M-1:0]   r_tid;
  logic [VCW-1:0] r_vc;
  logic [D-1:0]   r_dat;

  // ---------------- request path ----------------
  assign req_pld = {m_tid, MY_ID, m_wr, m_adr, m_vc, m_stb, m_dat, m_sb};
  // An out-of-range VC has no counter, so it is never granted.
  assign m_vc_ok = ({1'b0, m_vc} < VC_LIM);
  assign m_gnt   = req_rdy & m_vc_ok & (m_cnt < CNT_MAX);
  assign m_acc   = m_vld & m_gnt;

  XRs #(.D_WIDTH(TP)) u_req_rs (
    .clk  (clk),
    .rstn (rstn),
    .vldi (m_acc),
    .rdyi (req_rdy),
    .dati (req_pld),
    .vldo (t_vld),
    .rdyo (t_gnt),
    .dato (t_pld)
  );

  // ---------------- response path ----------------
  assign r_iid  = r_pld[RI +: N];
  assign r_tid  = r_pld[RT +: M];
  assign r_vc   = r_pld[RV +: VCW];
  assign r_dat  = r_pld[D-1:0];
  assign r_gnt  = rsp_rdy;
  assign r_acc  = r_vld & rsp_rdy;
  assign r_mis  = (r_iid != MY_ID);
  // Only responses that match this initiator and an outstanding request pass.
  assign r_enq  = r_acc & ~r_mis & (r_cnt != {CW{1'b0}});
  assign rsp_in = {r_tid, r_vc, r_dat};

  XRs #(.D_WIDTH(SW)) u_rsp_rs (
    .clk  (clk),
    .rstn (rstn),
    .vldi (r_enq),
    .rdyi (rsp_rdy),
    .dati (rsp_in),
    .vldo (s_vld),
    .rdyo (s_gnt),
    .dato (rsp_out)
  );

  assign {s_tid, s_vc, s_dat} = rsp_out;
  assign s_acc = s_vld & s_gnt;

  // ---------------- outstanding counters ----------------
  // Select counters for the request/response VCs, decode inc/dec, and OR busy.
  always_comb begin
    m_cnt = {CW{1'b0}};
    r_cnt = {CW{1'b0}};
    inc   = {VCN{1'b0}};
    dec   = {VCN{1'b0}};
    busy  = 1'b0;
    for (int v = 0; v < VCN; v++) begin
      m_cnt  = (m_vc == VCW'(v)) ? cnt[v] : m_cnt;
      r_cnt  = (r_vc == VCW'(v)) ? cnt[v] : r_cnt;
      inc[v] = m_acc & (m_vc == VCW'(v));
      dec[v] = s_acc & (s_vc == VCW'(v));
      busy   = busy | (cnt[v] != {CW{1'b0}});
    end
  end

  // Per-VC count update; simultaneous inc/dec cancel, both ends clamp.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < VCN; v++) begin
        cnt[v] <= {CW{1'b0}};
      end
    end else begin
      for (int v = 0; v < VCN; v++) begin
        case ({inc[v], dec[v]})
          2'b10:   cnt[v] <= (cnt[v] < CNT_MAX) ? cnt[v] + 1'b1 : cnt[v];
          2'b01:   cnt[v] <= (cnt[v] != {CW{1'b0}}) ? cnt[v] - 1'b1 : cnt[v];
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  // ---------------- error pulses ----------------
  // One-cycle flags for responses dropped on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_mis <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_mis <= r_acc & r_mis;
      err_unf <= r_acc & ~r_mis & (r_cnt == {CW{1'b0}});
    end
  end

endmodule
